// File: rtl/hwpe_ctrl_hub_if.sv
// Periph (TCDM-style) control port bundle between a cluster master and the HWPE control hub.
interface hwpe_ctrl_hub_if #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
);
  logic                   req;
  logic                   gnt;
  logic [AddrWidth-1:0]   addr;
  logic                   we;
  logic [DataWidth-1:0]   wdata;
  logic [DataWidth/8-1:0] strb;
  logic                   rvalid;
  logic [DataWidth-1:0]   rdata;
  logic                   err;

  // Cluster side: issues requests, receives grant and response
  modport master (
    output req, addr, we, wdata, strb,
    input  gnt, rvalid, rdata, err
  );

  // Hub side: accepts requests, produces grant and response
  modport slave (
    input  req, addr, we, wdata, strb,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/hwpe_ctrl_hub.sv
// Multi-HWPE control hub: decodes per-HWPE windows on the periph port, keeps one
// transaction in flight with per-HWPE timeout/fault isolation, and folds HWPE event
// pulses into sticky, maskable per-core mxip interrupts.
module hwpe_ctrl_hub #(
  parameter int unsigned NrHwpe        = 2,
  parameter int unsigned NrCores       = 9,
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned SelLsb        = 8,
  parameter int unsigned TimeoutCycles = 1024,
  parameter logic [DataWidth-1:0] ErrData = 32'hBADCAB1E
) (
  input  logic                          clk,
  input  logic                          rst_n,
  hwpe_ctrl_hub_if.slave                periph,
  output logic [NrHwpe-1:0]             hwpe_req,
  input  logic [NrHwpe-1:0]             hwpe_gnt,
  output logic [AddrWidth-1:0]          hwpe_addr,
  output logic                          hwpe_we,
  output logic [DataWidth-1:0]          hwpe_wdata,
  output logic [DataWidth/8-1:0]        hwpe_strb,
  input  logic [NrHwpe-1:0]             hwpe_rvalid,
  input  logic [NrHwpe*DataWidth-1:0]   hwpe_rdata,
  input  logic [NrHwpe*NrCores-1:0]     evt,
  output logic [NrCores-1:0]            mxip,
  output logic [NrHwpe-1:0]             fault,
  output logic                          busy
);
  localparam int unsigned SelW  = $clog2(NrHwpe + 1);
  localparam int unsigned WordW = SelLsb - 2;
  localparam int unsigned CntW  = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t                           state_reg;
  logic [SelW-1:0]                  sel_reg;
  logic [CntW-1:0]                  cnt_reg;
  logic                             rvalid_reg;
  logic [DataWidth-1:0]             rdata_reg;
  logic                             err_reg;
  logic [NrHwpe-1:0]                fault_reg;
  logic [NrHwpe-1:0][NrCores-1:0]   mask_reg, mask_next;
  logic [NrHwpe-1:0][NrCores-1:0]   pending_reg, pending_next;
  logic [NrCores-1:0]               mxip_reg, mxip_next;

  logic [SelW-1:0]      sel;
  logic [WordW-1:0]     word;
  logic                 is_hwpe, is_local, local_err, req_idle, hwpe_path, local_wr;
  logic                 gnt_sel, fault_sel, rvalid_sel;
  logic [DataWidth-1:0] rdata_sel, local_rdata;
  logic [NrCores-1:0]   wr_bits;

  assign sel       = periph.addr[SelLsb +: SelW];
  assign word      = periph.addr[SelLsb-1:2];
  assign is_hwpe   = sel < SelW'(NrHwpe);
  assign is_local  = sel == SelW'(NrHwpe);
  assign local_err = word >= WordW'(2 * NrHwpe);
  assign req_idle  = (state_reg == ST_IDLE) && periph.req;
  assign hwpe_path = is_hwpe && !fault_sel;
  assign local_wr  = req_idle && is_local && !local_err && periph.we;

  // Healthy HWPE targets grant through the HWPE; everything else is accepted at once
  assign periph.gnt    = req_idle && (hwpe_path ? gnt_sel : 1'b1);
  assign periph.rvalid = rvalid_reg;
  assign periph.rdata  = rdata_reg;
  assign periph.err    = err_reg;

  assign hwpe_addr  = periph.addr;
  assign hwpe_we    = periph.we;
  assign hwpe_wdata = periph.wdata;
  assign hwpe_strb  = periph.strb;

  assign mxip  = mxip_reg;
  assign fault = fault_reg;
  assign busy  = state_reg != ST_IDLE;

  // Expand byte strobes to per-core bit enables for the local registers
  always_comb begin
    wr_bits = '0;
    for (int b = 0; b < int'(NrCores); b++) wr_bits[b] = periph.strb[b/8];
  end

  // Select per-HWPE signals for the decoded and latched targets, local readback, irq OR
  always_comb begin
    gnt_sel     = 1'b0;
    fault_sel   = 1'b0;
    rvalid_sel  = 1'b0;
    rdata_sel   = '0;
    local_rdata = '0;
    mxip_next   = '0;
    for (int h = 0; h < int'(NrHwpe); h++) begin
      if (sel == SelW'(h)) begin
        gnt_sel   = hwpe_gnt[h];
        fault_sel = fault_reg[h];
      end
      if (sel_reg == SelW'(h)) begin
        rvalid_sel = hwpe_rvalid[h];
        rdata_sel  = hwpe_rdata[h*DataWidth +: DataWidth];
      end
      if (word == WordW'(2*h))     local_rdata = DataWidth'(mask_reg[h]);
      if (word == WordW'(2*h + 1)) local_rdata = DataWidth'(pending_reg[h]);
      mxip_next = mxip_next | (mask_reg[h] & pending_reg[h]);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < int'(NrHwpe); gi++) begin : gen_hwpe
      logic mask_hit, pend_hit;
      logic [NrCores-1:0] clr_bits;
      assign mask_hit = local_wr && (word == WordW'(2*gi));
      assign pend_hit = local_wr && (word == WordW'(2*gi + 1));
      assign clr_bits = pend_hit ? (periph.wdata[NrCores-1:0] & wr_bits) : '0;
      assign mask_next[gi] = mask_hit
          ? ((mask_reg[gi] & ~wr_bits) | (periph.wdata[NrCores-1:0] & wr_bits))
          : mask_reg[gi];
      // New events are OR-ed after the clear so a simultaneous set wins
      assign pending_next[gi] = (pending_reg[gi] & ~clr_bits) | evt[gi*NrCores +: NrCores];
      assign hwpe_req[gi] = req_idle && (sel == SelW'(gi)) && !fault_reg[gi];
    end
  endgenerate

  // Interrupt state: mask/pending registers and the registered mxip output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_reg    <= '0;
      pending_reg <= '0;
      mxip_reg    <= '0;
    end else begin
      mask_reg    <= mask_next;
      pending_reg <= pending_next;
      mxip_reg    <= mxip_next;
    end
  end

  // Transaction FSM: accept in IDLE, wait on the HWPE with timeout, pulse response in RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      sel_reg    <= '0;
      cnt_reg    <= '0;
      rvalid_reg <= 1'b0;
      rdata_reg  <= '0;
      err_reg    <= 1'b0;
      fault_reg  <= '0;
    end else begin
      rvalid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (periph.req) begin
            if (hwpe_path) begin
              if (gnt_sel) begin
                state_reg <= ST_WAIT;
                sel_reg   <= sel;
                cnt_reg   <= '0;
              end
            end else begin
              state_reg  <= ST_RESP;
              rvalid_reg <= 1'b1;
              if (is_local && !local_err) begin
                err_reg   <= 1'b0;
                rdata_reg <= periph.we ? '0 : local_rdata;
              end else begin
                err_reg   <= 1'b1;
                rdata_reg <= ErrData;
              end
            end
          end
        end
        ST_WAIT: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (rvalid_sel) begin
            state_reg  <= ST_RESP;
            rvalid_reg <= 1'b1;
            rdata_reg  <= rdata_sel;
            err_reg    <= 1'b0;
          end else if ((TimeoutCycles != 0) && (cnt_reg == CntLast)) begin
            state_reg  <= ST_RESP;
            rvalid_reg <= 1'b1;
            rdata_reg  <= ErrData;
            err_reg    <= 1'b1;
            fault_reg  <= fault_reg | (NrHwpe'(1) << sel_reg);
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end
endmodule
